rename_nw: RTL

- N-wide register-rename stage. Successor to the single-lane rename stage.
- Sits between the decode FIFO and the ROB/issue queue/LSQ.
- Owns the speculative map table (F-RAT) and per-physical-register busy bits internally.
- Each cycle renames the longest in-order prefix of up to WIDTH decoded instructions that fits the available free registers, ROB slots, IQ slots and LSQ slots.
- Resolves intra-group dependencies by bypass.

---
 rtl/rename_pkg.sv | 22 ++
 rtl/rename_alloc_ctl.sv | 79 +++++++
 rtl/rename_nw.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Shared definitions for the N-wide rename stage: stall reasons, the zero
// physical register and the lane-field offset helper.
package rename_pkg;

  typedef enum logic [2:0] {
    STALL_NONE     = 3'd0,
    STALL_NO_INPUT = 3'd1,
    STALL_ROB      = 3'd2,
    STALL_FREE     = 3'd3,
    STALL_IQ       = 3'd4,
    STALL_LSQ      = 3'd5,
    STALL_FLUSH    = 3'd6
  } stall_e;

  localparam int PHYS_ZERO = 0;

  // Bit offset of lane `lane` inside a bus of `field_w`-bit lane fields.
  function automatic int lane_lsb(input int lane, input int field_w);
    return lane * field_w;
  endfunction

endpackage

// File: rtl/rename_alloc_ctl.sv
// Decides how many in-order lanes fit this cycle's free registers and
// ROB/IQ/LSQ slots, and gives each lane its index into the free-list heads.
module rename_alloc_ctl
  import rename_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                rst,
  input  logic                flush,
  input  logic [WIDTH-1:0]    valid,
  input  logic [WIDTH-1:0]    need_reg,
  input  logic [WIDTH-1:0]    need_mem,
  input  logic [CW-1:0]       free_count,
  input  logic [CW-1:0]       rob_slots,
  input  logic [CW-1:0]       iq_slots,
  input  logic [CW-1:0]       lsq_slots,
  output logic [CW-1:0]       accept,
  output logic [CW-1:0]       grabbed,
  output logic [WIDTH*CW-1:0] alloc_idx,
  output logic                blocked,
  output stall_e              reason
);

  always_comb begin
    int regs;
    int mems;
    int prior_regs;
    int offered;
    int taken;
    logic stop;
    accept     = '0;
    grabbed    = '0;
    alloc_idx  = '0;
    blocked    = 1'b0;
    reason     = STALL_NONE;
    regs       = 0;
    mems       = 0;
    prior_regs = 0;
    offered    = 0;
    taken      = 0;
    stop       = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc_idx[lane_lsb(i, CW) +: CW] = CW'(prior_regs);
      prior_regs = prior_regs + int'(need_reg[i]);
      if (valid[i]) offered = offered + 1;
      // The first lane that fails a check ends the prefix; its reason is kept.
      if (!stop) begin
        if (!valid[i]) begin
          stop = 1'b1;
          if (i == 0) reason = STALL_NO_INPUT;
        end else if (i + 1 > int'(rob_slots)) begin
          stop   = 1'b1;
          reason = STALL_ROB;
        end else if (regs + int'(need_reg[i]) > int'(free_count)) begin
          stop   = 1'b1;
          reason = STALL_FREE;
        end else if (i + 1 > int'(iq_slots)) begin
          stop   = 1'b1;
          reason = STALL_IQ;
        end else if (mems + int'(need_mem[i]) > int'(lsq_slots)) begin
          stop   = 1'b1;
          reason = STALL_LSQ;
        end else begin
          taken = taken + 1;
          regs  = regs + int'(need_reg[i]);
          mems  = mems + int'(need_mem[i]);
        end
      end
    end
    if (!(rst || flush)) begin
      accept  = CW'(taken);
      grabbed = CW'(regs);
    end
    blocked = flush || (taken < offered);
    if (flush) reason = STALL_FLUSH;
  end

endmodule

// File: rtl/rename_nw.sv
// N-wide register rename stage with speculative map table, busy bits and
// in-group bypass. Define RENAME_STATS_EN to add the Stats_bus counters.
module rename_nw
  import rename_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int NUM_ARCH = 32,
  parameter int LOG_ARCH = 5,
  parameter int NUM_PHYS = 64,
  parameter int LOG_PHYS = 6,
  parameter int CW       = $clog2(WIDTH + 1)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [WIDTH-1:0]             In_valid,
  input  logic [WIDTH*LOG_ARCH-1:0]    In_src_a,
  input  logic [WIDTH*LOG_ARCH-1:0]    In_src_b,
  input  logic [WIDTH*LOG_ARCH-1:0]    In_dst,
  input  logic [WIDTH-1:0]             In_reg_write,
  input  logic [WIDTH-1:0]             In_mem,
  input  logic [WIDTH*LOG_PHYS-1:0]    Free_regs,
  input  logic [CW-1:0]                Free_count,
  input  logic [CW-1:0]                Rob_slots,
  input  logic [CW-1:0]                Iq_slots,
  input  logic [CW-1:0]                Lsq_slots,
  input  logic                         Wakeup_valid,
  input  logic [LOG_PHYS-1:0]          Wakeup_phys,
  input  logic                         Flush,
  input  logic [NUM_ARCH*LOG_PHYS-1:0] Flush_map,
  output logic [CW-1:0]                Accept,
  output logic [CW-1:0]                Grabbed_regs,
  output logic [WIDTH-1:0]             Out_valid,
  output logic [WIDTH*LOG_PHYS-1:0]    Out_src_a_phys,
  output logic [WIDTH*LOG_PHYS-1:0]    Out_src_b_phys,
  output logic [WIDTH-1:0]             Out_src_a_rdy,
  output logic [WIDTH-1:0]             Out_src_b_rdy,
  output logic [WIDTH-1:0]             Out_dst_en,
  output logic [WIDTH*LOG_PHYS-1:0]    Out_dst_phys,
  output logic [WIDTH*LOG_PHYS-1:0]    Out_old_phys,
  output logic                         Blocked,
  output logic [2:0]                   Stall_reason
`ifdef RENAME_STATS_EN
  ,
  output logic [5*32-1:0]              Stats_bus
`endif
);

  logic [LOG_PHYS-1:0]       map [NUM_ARCH];
  logic [NUM_PHYS-1:0]       busy;
  logic [WIDTH-1:0]          need_reg;
  logic [CW-1:0]             accept;
  logic [CW-1:0]             grabbed;
  logic [WIDTH*CW-1:0]       alloc_idx;
  logic                      blocked;
  stall_e                    reason;
  logic [WIDTH-1:0]          take;
  logic [WIDTH-1:0]          dst_en;
  logic [WIDTH*LOG_PHYS-1:0] new_phys;
  logic [WIDTH*LOG_PHYS-1:0] src_a_phys;
  logic [WIDTH*LOG_PHYS-1:0] src_b_phys;
  logic [WIDTH*LOG_PHYS-1:0] dst_phys;
  logic [WIDTH*LOG_PHYS-1:0] old_phys;
  logic [WIDTH-1:0]          src_a_rdy;
  logic [WIDTH-1:0]          src_b_rdy;

  // Arch register 0 is hard-wired and never gets a new physical register.
  always_comb begin
    need_reg = '0;
    for (int i = 0; i < WIDTH; i++)
      need_reg[i] = In_reg_write[i] && (In_dst[lane_lsb(i, LOG_ARCH) +: LOG_ARCH] != '0);
  end

  rename_alloc_ctl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_alloc_ctl (
    .rst        (RESET),
    .flush      (Flush),
    .valid      (In_valid),
    .need_reg   (need_reg),
    .need_mem   (In_mem),
    .free_count (Free_count),
    .rob_slots  (Rob_slots),
    .iq_slots   (Iq_slots),
    .lsq_slots  (Lsq_slots),
    .accept     (accept),
    .grabbed    (grabbed),
    .alloc_idx  (alloc_idx),
    .blocked    (blocked),
    .reason     (reason)
  );

  assign Accept       = accept;
  assign Grabbed_regs = grabbed;

  always_comb begin
    int idx;
    take     = '0;
    dst_en   = '0;
    new_phys = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx       = int'(alloc_idx[lane_lsb(i, CW) +: CW]);
      take[i]   = i < int'(accept);
      dst_en[i] = take[i] && need_reg[i];
      new_phys[lane_lsb(i, LOG_PHYS) +: LOG_PHYS] = Free_regs[lane_lsb(idx, LOG_PHYS) +: LOG_PHYS];
    end
  end

  // Sources and old mapping come from the latest earlier allocating lane in
  // the group, otherwise from the map table.
  always_comb begin
    logic [LOG_ARCH-1:0] sa, sb, da, dj;
    logic [LOG_PHYS-1:0] pa, pb, po;
    logic                ra, rb;
    src_a_phys = '0;
    src_b_phys = '0;
    dst_phys   = '0;
    old_phys   = '0;
    src_a_rdy  = '0;
    src_b_rdy  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sa = In_src_a[lane_lsb(i, LOG_ARCH) +: LOG_ARCH];
      sb = In_src_b[lane_lsb(i, LOG_ARCH) +: LOG_ARCH];
      da = In_dst[lane_lsb(i, LOG_ARCH) +: LOG_ARCH];
      pa = map[sa];
      pb = map[sb];
      po = map[da];
      ra = !busy[pa];
      rb = !busy[pb];
      for (int j = 0; j < i; j++) begin
        dj = In_dst[lane_lsb(j, LOG_ARCH) +: LOG_ARCH];
        if (need_reg[j] && dj == sa) begin
          pa = new_phys[lane_lsb(j, LOG_PHYS) +: LOG_PHYS];
          ra = 1'b0;
        end
        if (need_reg[j] && dj == sb) begin
          pb = new_phys[lane_lsb(j, LOG_PHYS) +: LOG_PHYS];
          rb = 1'b0;
        end
        if (need_reg[j] && dj == da) po = new_phys[lane_lsb(j, LOG_PHYS) +: LOG_PHYS];
      end
      if (sa == '0) begin
        pa = LOG_PHYS'(PHYS_ZERO);
        ra = 1'b1;
      end
      if (sb == '0) begin
        pb = LOG_PHYS'(PHYS_ZERO);
        rb = 1'b1;
      end
      if (Wakeup_valid && Wakeup_phys == pa) ra = 1'b1;
      if (Wakeup_valid && Wakeup_phys == pb) rb = 1'b1;
      src_a_phys[lane_lsb(i, LOG_PHYS) +: LOG_PHYS] = pa;
      src_b_phys[lane_lsb(i, LOG_PHYS) +: LOG_PHYS] = pb;
      src_a_rdy[i] = ra;
      src_b_rdy[i] = rb;
      if (dst_en[i]) begin
        dst_phys[lane_lsb(i, LOG_PHYS) +: LOG_PHYS] = new_phys[lane_lsb(i, LOG_PHYS) +: LOG_PHYS];
        old_phys[lane_lsb(i, LOG_PHYS) +: LOG_PHYS] = po;
      end
    end
  end

  // Later lanes overwrite earlier ones, and allocation overrides a same-cycle wakeup.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int a = 0; a < NUM_ARCH; a++) map[a] <= LOG_PHYS'(a);
      busy <= '0;
    end else if (Flush) begin
      for (int a = 0; a < NUM_ARCH; a++) map[a] <= Flush_map[lane_lsb(a, LOG_PHYS) +: LOG_PHYS];
      busy <= '0;
    end else begin
      if (Wakeup_valid) busy[Wakeup_phys] <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (dst_en[i]) begin
          map[In_dst[lane_lsb(i, LOG_ARCH) +: LOG_ARCH]] <= new_phys[lane_lsb(i, LOG_PHYS) +: LOG_PHYS];
          busy[new_phys[lane_lsb(i, LOG_PHYS) +: LOG_PHYS]] <= 1'b1;
        end
      end
    end
  end

  // Output stage: one cycle after acceptance.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Out_valid      <= '0;
      Out_src_a_phys <= '0;
      Out_src_b_phys <= '0;
      Out_src_a_rdy  <= '0;
      Out_src_b_rdy  <= '0;
      Out_dst_en     <= '0;
      Out_dst_phys   <= '0;
      Out_old_phys   <= '0;
      Blocked        <= 1'b0;
      Stall_reason   <= '0;
    end else begin
      Out_valid      <= take;
      Out_src_a_phys <= src_a_phys;
      Out_src_b_phys <= src_b_phys;
      Out_src_a_rdy  <= src_a_rdy;
      Out_src_b_rdy  <= src_b_rdy;
      Out_dst_en     <= dst_en;
      Out_dst_phys   <= dst_phys;
      Out_old_phys   <= old_phys;
      Blocked        <= blocked;
      Stall_reason   <= reason;
    end
  end

`ifdef RENAME_STATS_EN
  logic [31:0] stall_cnt [4];
  logic [31:0] renamed_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int r = 0; r < 4; r++) stall_cnt[r] <= '0;
      renamed_cnt <= '0;
    end else begin
      for (int r = 0; r < 4; r++)
        if (int'(reason) == r + 2 && stall_cnt[r] != '1) stall_cnt[r] <= stall_cnt[r] + 32'd1;
      if (renamed_cnt > ~32'(accept)) renamed_cnt <= '1;
      else renamed_cnt <= renamed_cnt + 32'(accept);
    end
  end

  assign Stats_bus = {renamed_cnt, stall_cnt[3], stall_cnt[2], stall_cnt[1], stall_cnt[0]};
`endif

endmodule
